// File: rtl/serial_cmd_rx_if.sv
// Decoded-command bus from the serial command receiver to the LED register bank.
interface serial_cmd_rx_if;
  logic       CMD_VALID;
  logic [2:0] CMD_INSTR;
  logic [4:0] CMD_ADDR;
  logic       CMD_ERR;
  logic [7:0] ERR_COUNT;
  logic       BUSY;

  modport master (output CMD_VALID, CMD_INSTR, CMD_ADDR, CMD_ERR, ERR_COUNT, BUSY);
  modport slave  (input  CMD_VALID, CMD_INSTR, CMD_ADDR, CMD_ERR, ERR_COUNT, BUSY);
endinterface

// File: rtl/serial_cmd_rx.sv
// Serial command receiver: oversamples SCLK/DATA/LATCH, shifts in MSB-first words
// and strobes validated instruction/address (or a frame error) to the LED bank.
module serial_cmd_rx #(
  parameter int MSB      = 8,
  parameter int NUM_LEDS = 23,
  parameter int TIMEOUT  = 1000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            SCLK,
  input  logic            DATA,
  input  logic            LATCH,
  serial_cmd_rx_if.master cmd
);

  localparam logic [3:0]  FULL_CNT = 4'(MSB);
  localparam logic [5:0]  ADDR_LIM = 6'(NUM_LEDS);
  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCHED} state_t;

  state_t         state, state_nxt;
  logic           sclk_p0, sclk_p1, sclk_p2;
  logic           data_p0, data_p1;
  logic           latch_p0, latch_p1, latch_p2;
  logic [1:0]     settle;
  logic           sclk_rise_p3, latch_rise_p3;
  logic [MSB-1:0] shreg, shreg_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [15:0]    tmo, tmo_nxt;
  logic           valid_q, valid_nxt;
  logic           err_q, err_nxt;
  logic [2:0]     instr_q, instr_nxt;
  logic [4:0]     addr_q, addr_nxt;
  logic [7:0]     errcnt_q, errcnt_nxt;
  logic           do_eval;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // p0/p1: synchronisers; p2: edge-detect history; p3: registered edge pulses.
  // latch_p2 is held at 1 until p1 carries real samples, so a LATCH held high
  // across reset release never looks like a rising edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sclk_p0       <= 1'b0;
      sclk_p1       <= 1'b0;
      sclk_p2       <= 1'b0;
      data_p0       <= 1'b0;
      data_p1       <= 1'b0;
      latch_p0      <= 1'b0;
      latch_p1      <= 1'b0;
      latch_p2      <= 1'b1;
      settle        <= 2'd0;
      sclk_rise_p3  <= 1'b0;
      latch_rise_p3 <= 1'b0;
    end else begin
      sclk_p0       <= SCLK;
      sclk_p1       <= sclk_p0;
      sclk_p2       <= sclk_p1;
      data_p0       <= DATA;
      data_p1       <= data_p0;
      latch_p0      <= LATCH;
      latch_p1      <= latch_p0;
      latch_p2      <= (settle == 2'd2) ? latch_p1 : latch_p2;
      settle        <= (settle == 2'd2) ? settle : settle + 2'd1;
      sclk_rise_p3  <= sclk_p1 & ~sclk_p2;
      latch_rise_p3 <= latch_p1 & ~latch_p2;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      tmo      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      instr_q  <= '0;
      addr_q   <= '0;
      errcnt_q <= '0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      tmo      <= tmo_nxt;
      valid_q  <= valid_nxt;
      err_q    <= err_nxt;
      instr_q  <= instr_nxt;
      addr_q   <= addr_nxt;
      errcnt_q <= errcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
    tmo_nxt    = tmo;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    instr_nxt  = instr_q;
    addr_nxt   = addr_q;
    errcnt_nxt = errcnt_q;
    do_eval    = 1'b0;
    unique case (state)
      IDLE: begin
        tmo_nxt = '0;
        if (latch_rise_p3) begin
          do_eval   = 1'b1;
          state_nxt = LATCHED;
        end else if (sclk_rise_p3) begin
          shreg_nxt = {shreg[MSB-2:0], data_p1};
          cnt_nxt   = sat_inc4(cnt);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Latch wins over a coincident SCLK rise: that bit is dropped.
        if (latch_rise_p3) begin
          do_eval   = 1'b1;
          tmo_nxt   = '0;
          state_nxt = LATCHED;
        end else if (sclk_rise_p3) begin
          shreg_nxt = {shreg[MSB-2:0], data_p1};
          cnt_nxt   = sat_inc4(cnt);
          tmo_nxt   = '0;
        end else if (tmo == TMO_LIM) begin
          cnt_nxt   = '0;
          tmo_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt   = tmo + 16'd1;
        end
      end
      LATCHED: begin
        tmo_nxt = '0;
        if (!latch_p1) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (do_eval) begin
      if (cnt == FULL_CNT && {1'b0, shreg[4:0]} < ADDR_LIM) begin
        valid_nxt = 1'b1;
        instr_nxt = shreg[MSB-1:MSB-3];
        addr_nxt  = shreg[4:0];
      end else begin
        err_nxt    = 1'b1;
        errcnt_nxt = sat_inc8(errcnt_q);
      end
    end
  end

  assign cmd.CMD_VALID = valid_q;
  assign cmd.CMD_ERR   = err_q;
  assign cmd.CMD_INSTR = instr_q;
  assign cmd.CMD_ADDR  = addr_q;
  assign cmd.ERR_COUNT = errcnt_q;
  assign cmd.BUSY      = (state == SHIFT);

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx: expected commands/errors are queued when a
// frame is latched and compared when the receiver strobes its output.
module tb_serial_cmd_rx;
  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic SCLK  = 1'b0;
  logic DATA  = 1'b0;
  logic LATCH = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  typedef struct packed {
    logic        is_err;
    logic [2:0]  instr;
    logic [4:0]  addr;
    logic [7:0]  errcnt;
    logic [31:0] lat_edge;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] m_sh    = '0;
  int         m_cnt   = 0;
  logic [2:0] m_instr = '0;
  logic [4:0] m_addr  = '0;
  logic [7:0] m_err   = '0;

  serial_cmd_rx_if cmd();

  serial_cmd_rx #(.MSB(8), .NUM_LEDS(23), .TIMEOUT(1000)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .SCLK  (SCLK),
    .DATA  (DATA),
    .LATCH (LATCH),
    .cmd   (cmd)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every output strobe must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (cmd.CMD_VALID === 1'b1 || cmd.CMD_ERR === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed valid=%0b err=%0b expected=no pulse",
               cmd.CMD_VALID, cmd.CMD_ERR);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("pulse_valid", 32'(cmd.CMD_VALID), mon_e.is_err ? 32'd0 : 32'd1);
        chk("pulse_err",   32'(cmd.CMD_ERR),   mon_e.is_err ? 32'd1 : 32'd0);
        chk("pulse_excl",  32'(cmd.CMD_VALID & cmd.CMD_ERR), 32'd0);
        chk("pulse_instr", 32'(cmd.CMD_INSTR), 32'(mon_e.instr));
        chk("pulse_addr",  32'(cmd.CMD_ADDR),  32'(mon_e.addr));
        chk("pulse_errcnt", 32'(cmd.ERR_COUNT), 32'(mon_e.errcnt));
        chk("pulse_latency", 32'(cyc) - mon_e.lat_edge, 32'd3);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    DATA = b;
    tick(1);
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
    tick(4);
    m_sh = {m_sh[6:0], b};
    if (m_cnt < 15) m_cnt++;
  endtask

  task automatic send_bits(input logic [8:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic push_exp();
    exp_t e;
    if (m_cnt == 8 && m_sh[4:0] < 5'd23) begin
      m_instr  = m_sh[7:5];
      m_addr   = m_sh[4:0];
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
      if (m_err != 8'd255) m_err++;
    end
    e.instr    = m_instr;
    e.addr     = m_addr;
    e.errcnt   = m_err;
    e.lat_edge = 32'(cyc + 1);
    sb.push_back(e);
    m_cnt = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_latch();
    push_exp();
    LATCH = 1'b1;
    tick(4);
    LATCH = 1'b0;
    tick(4);
    drain();
  endtask

  initial begin
    tick(3);
    chk("rst_valid",  32'(cmd.CMD_VALID), 32'd0);
    chk("rst_err",    32'(cmd.CMD_ERR),   32'd0);
    chk("rst_instr",  32'(cmd.CMD_INSTR), 32'd0);
    chk("rst_addr",   32'(cmd.CMD_ADDR),  32'd0);
    chk("rst_errcnt", 32'(cmd.ERR_COUNT), 32'd0);
    chk("rst_busy",   32'(cmd.BUSY),      32'd0);
    RESET = 1'b1;
    tick(3);

    send_bits(9'h0A5, 8);
    do_latch();
    chk("a5_instr", 32'(cmd.CMD_INSTR), 32'd5);
    chk("a5_addr",  32'(cmd.CMD_ADDR),  32'd5);

    send_bits(9'h077, 8);
    do_latch();
    chk("addr23_errcnt", 32'(cmd.ERR_COUNT), 32'd1);
    chk("addr23_addr",   32'(cmd.CMD_ADDR),  32'd5);

    send_bits(9'h025, 7);
    do_latch();
    send_bits(9'h141, 9);
    do_latch();
    chk("short_long_errcnt", 32'(cmd.ERR_COUNT), 32'd3);

    send_bits(9'h00B, 4);
    chk("busy_partial", 32'(cmd.BUSY), 32'd1);
    tick(900);
    chk("busy_before_timeout", 32'(cmd.BUSY), 32'd1);
    tick(200);
    chk("busy_after_timeout", 32'(cmd.BUSY), 32'd0);
    chk("timeout_errcnt", 32'(cmd.ERR_COUNT), 32'd3);
    m_cnt = 0;
    send_bits(9'h022, 8);
    do_latch();
    chk("x22_instr", 32'(cmd.CMD_INSTR), 32'd1);
    chk("x22_addr",  32'(cmd.CMD_ADDR),  32'd2);

    // SCLK and LATCH rise together, then SCLK toggles while LATCH is held.
    send_bits(9'h06C, 8);
    DATA = 1'b1;
    tick(1);
    push_exp();
    SCLK  = 1'b1;
    LATCH = 1'b1;
    tick(4);
    SCLK = 1'b0;
    tick(4);
    SCLK = 1'b1;
    tick(2);
    chk("busy_latched", 32'(cmd.BUSY), 32'd0);
    tick(2);
    SCLK = 1'b0;
    tick(4);
    LATCH = 1'b0;
    tick(4);
    drain();
    chk("simul_instr", 32'(cmd.CMD_INSTR), 32'd3);
    chk("simul_addr",  32'(cmd.CMD_ADDR),  32'd12);
    do_latch();

    send_bits(9'h005, 3);
    #2 RESET = 1'b0;
    #1;
    chk("midrst_valid",  32'(cmd.CMD_VALID), 32'd0);
    chk("midrst_err",    32'(cmd.CMD_ERR),   32'd0);
    chk("midrst_instr",  32'(cmd.CMD_INSTR), 32'd0);
    chk("midrst_addr",   32'(cmd.CMD_ADDR),  32'd0);
    chk("midrst_errcnt", 32'(cmd.ERR_COUNT), 32'd0);
    chk("midrst_busy",   32'(cmd.BUSY),      32'd0);
    LATCH   = 1'b1;
    m_sh    = '0;
    m_cnt   = 0;
    m_instr = '0;
    m_addr  = '0;
    m_err   = '0;
    tick(2);
    RESET = 1'b1;
    tick(10);
    chk("latch_held_errcnt", 32'(cmd.ERR_COUNT), 32'd0);
    chk("latch_held_queue",  32'(sb.size()),     32'd0);
    LATCH = 1'b0;
    tick(5);
    send_bits(9'h015, 5);
    do_latch();
    chk("post_rst_errcnt", 32'(cmd.ERR_COUNT), 32'd1);

    for (int k = 0; k < 260; k++) do_latch();
    chk("sat_errcnt", 32'(cmd.ERR_COUNT), 32'd255);
    send_bits(9'h016, 8);
    do_latch();
    chk("sat_keep_errcnt", 32'(cmd.ERR_COUNT), 32'd255);
    chk("x16_instr", 32'(cmd.CMD_INSTR), 32'd0);
    chk("x16_addr",  32'(cmd.CMD_ADDR),  32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
